// File: rtl/mem_access_unit.sv
// Load/store requester for the byte-addressed data RAM.
// Handles one transaction at a time: IDLE -> ACCESS -> RESP.
module mem_access_unit #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int WORD_LENGTH = 8,
  parameter logic [ADDRESS_LENGTH-1:0] ADDR_MAX = 32'h1FFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_we,
  input  logic [2:0] req_funct3,
  input  logic [ADDRESS_LENGTH-1:0] req_addr,
  input  logic [ADDRESS_LENGTH-1:0] req_wdata,
  output logic resp_valid,
  input  logic resp_ready,
  output logic [ADDRESS_LENGTH-1:0] resp_data,
  output logic resp_err,
  output logic [ADDRESS_LENGTH-1:0] a,
  output logic [ADDRESS_LENGTH-1:0] wd,
  output logic sb,
  output logic sh,
  output logic sw,
  input  logic [ADDRESS_LENGTH-1:0] rd
);

  localparam int L = ADDRESS_LENGTH;
  localparam int B = WORD_LENGTH;
  localparam int H = 2 * WORD_LENGTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_n;

  logic         we_q;
  logic [2:0]   f3_q;
  logic [L-1:0] addr_q;
  logic [L-1:0] wdata_q;
  logic [L-1:0] data_q;
  logic         err_q;

  logic         is_b, is_h, is_w;
  logic [2:0]   nbytes;
  logic [L:0]   last;
  logic         f3_ok;
  logic         in_range;
  logic         legal;
  logic [L-1:0] ld_data;

  assign is_b = (f3_q[1:0] == 2'b00);
  assign is_h = (f3_q[1:0] == 2'b01);
  assign is_w = (f3_q[1:0] == 2'b10);

  always_comb begin
    nbytes = 3'd4;
    unique case (1'b1)
      is_b:    nbytes = 3'd1;
      is_h:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // One extra bit so an address near the top wraps into "out of range"
  assign last = {1'b0, addr_q} + (L+1)'(nbytes) - (L+1)'(1);
  assign in_range = (last <= {1'b0, ADDR_MAX});

  always_comb begin
    f3_ok = 1'b0;
    if (we_q)
      f3_ok = f3_q inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  assign legal = f3_ok && in_range;

  always_comb begin
    ld_data = '0;
    case (f3_q)
      3'b000:  ld_data = {{(L-B){rd[B-1]}}, rd[B-1:0]};
      3'b001:  ld_data = {{(L-H){rd[H-1]}}, rd[H-1:0]};
      3'b010:  ld_data = rd;
      3'b100:  ld_data = {{(L-B){1'b0}}, rd[B-1:0]};
      3'b101:  ld_data = {{(L-H){1'b0}}, rd[H-1:0]};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    a  = '0;
    wd = '0;
    sb = 1'b0;
    sh = 1'b0;
    sw = 1'b0;
    if (state == ACCESS) begin
      a  = addr_q;
      wd = wdata_q;
      if (we_q && legal) begin
        unique case (1'b1)
          is_b:    sb = 1'b1;
          is_h:    sh = 1'b1;
          is_w:    sw = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS) begin
        data_q <= (legal && !we_q) ? ld_data : '0;
        err_q  <= !legal;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_data  = data_q;
  assign resp_err   = err_q;

endmodule
